reg_file_access_arbiter: RTL

// Shares the register-file storage between two requesters: the AXI-lite slave front end (bus) and user logic (fab).

---
 rtl/reg_file_access_arbiter_if.sv | 25 ++
 rtl/reg_file_access_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_access_arbiter_if.sv
// Request/response channel between one requester and the register-file arbiter.
interface reg_file_access_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/reg_file_access_arbiter.sv
// Register-file access arbiter: bus/fab round-robin; 4-stage IDLE/DECODE/EXEC/RESP walk per access.
// Response is available 3 cycles after the handshake; rsp stays held until rsp_ready and blocks new grants.
package reg_file_pkg;
   localparam int REG_FILE_NUM_REGISTERS  = 8;
   localparam int REG_FILE_AXI_ADDR_WIDTH = 8;

   typedef struct packed {
      logic [REG_FILE_AXI_ADDR_WIDTH-1:0] addr;
      logic                               memory_mapped;
      logic                               trigger_on_write;
      logic                               clear_on_read;
   } reg_map_entry_t;

   // Entries 6 and 7 share an address on purpose; the higher id owns it.
   localparam reg_map_entry_t AXI_LITE_REG_MAP_TABLE [REG_FILE_NUM_REGISTERS] = '{
      '{8'h00, 1'b1, 1'b0, 1'b0},
      '{8'h04, 1'b1, 1'b0, 1'b1},
      '{8'h08, 1'b1, 1'b1, 1'b0},
      '{8'h0C, 1'b0, 1'b0, 1'b0},
      '{8'h10, 1'b0, 1'b1, 1'b0},
      '{8'h14, 1'b1, 1'b0, 1'b0},
      '{8'h18, 1'b1, 1'b0, 1'b0},
      '{8'h18, 1'b0, 1'b0, 1'b0}
   };
endpackage

module reg_file_access_arbiter
   import reg_file_pkg::*;
#(
   parameter int NUM_REGS   = REG_FILE_NUM_REGISTERS,
   parameter int ADDR_WIDTH = REG_FILE_AXI_ADDR_WIDTH,
   parameter int DATA_WIDTH = 32
) (
   input  logic                           clk,
   input  logic                           rst_n,
   reg_file_access_arbiter_if.slave       bus,
   reg_file_access_arbiter_if.slave       fab,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            reg_trig,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] ext_rdata,
   output logic [NUM_REGS-1:0]            ext_we,
   output logic [DATA_WIDTH-1:0]          ext_wdata
);
   localparam int ID_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   typedef enum logic [1:0] {IDLE, DECODE, EXEC, RESP} state_e;
   state_e state_q, state_d;

   logic                                 last_fab_q, src_fab_q, we_q;
   logic [ADDR_WIDTH-1:0]                addr_q;
   logic [DATA_WIDTH-1:0]                wdata_q, rdata_q;
   logic                                 hit_q, mm_q, trigf_q, cor_q, err_q;
   logic [ID_W-1:0]                      id_q;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  mem_q;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  ext_arr;
   logic [NUM_REGS-1:0]                  trig_q;

   logic                                 hit_d, mm_d, trigf_d, cor_d;
   logic [ID_W-1:0]                      id_d;
   logic                                 grant_fab, accept, rsp_ready_sel;

   assign reg_q    = mem_q;
   assign reg_trig = trig_q;
   assign ext_arr  = ext_rdata;

   // On a tie, grant the port that did not win last time.
   always_comb begin
      grant_fab = fab.req_valid;
      if (bus.req_valid && fab.req_valid) begin
         grant_fab = ~last_fab_q;
      end
   end

   assign accept        = (state_q == IDLE) && (bus.req_valid || fab.req_valid);
   assign rsp_ready_sel = src_fab_q ? fab.rsp_ready : bus.rsp_ready;

   // Ascending scan: a later (higher id) match overrides earlier ones.
   always_comb begin
      hit_d   = 1'b0;
      id_d    = '0;
      mm_d    = 1'b0;
      trigf_d = 1'b0;
      cor_d   = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (AXI_LITE_REG_MAP_TABLE[i].addr == addr_q) begin
            hit_d   = 1'b1;
            id_d    = ID_W'(i);
            mm_d    = AXI_LITE_REG_MAP_TABLE[i].memory_mapped;
            trigf_d = AXI_LITE_REG_MAP_TABLE[i].trigger_on_write;
            cor_d   = AXI_LITE_REG_MAP_TABLE[i].clear_on_read;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = DECODE;
         DECODE:  state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready_sel) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = 1'b0;
      fab.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      fab.rsp_valid = 1'b0;
      bus.rsp_rdata = '0;
      fab.rsp_rdata = '0;
      bus.rsp_err   = 1'b0;
      fab.rsp_err   = 1'b0;
      ext_we        = '0;
      ext_wdata     = '0;
      case (state_q)
         IDLE: begin
            bus.req_ready = bus.req_valid && !grant_fab;
            fab.req_ready = fab.req_valid && grant_fab;
         end
         EXEC: begin
            if (hit_q && we_q && !mm_q) begin
               ext_we[id_q] = 1'b1;
               ext_wdata    = wdata_q;
            end
         end
         RESP: begin
            if (src_fab_q) begin
               fab.rsp_valid = 1'b1;
               fab.rsp_rdata = rdata_q;
               fab.rsp_err   = err_q;
            end else begin
               bus.rsp_valid = 1'b1;
               bus.rsp_rdata = rdata_q;
               bus.rsp_err   = err_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_fab_q <= 1'b1;
         src_fab_q  <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         hit_q      <= 1'b0;
         id_q       <= '0;
         mm_q       <= 1'b0;
         trigf_q    <= 1'b0;
         cor_q      <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         mem_q      <= '0;
         trig_q     <= '0;
      end else begin
         trig_q <= '0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  last_fab_q <= grant_fab;
                  src_fab_q  <= grant_fab;
                  we_q       <= grant_fab ? fab.req_we    : bus.req_we;
                  addr_q     <= grant_fab ? fab.req_addr  : bus.req_addr;
                  wdata_q    <= grant_fab ? fab.req_wdata : bus.req_wdata;
               end
            end
            DECODE: begin
               hit_q   <= hit_d;
               id_q    <= id_d;
               mm_q    <= mm_d;
               trigf_q <= trigf_d;
               cor_q   <= cor_d;
               err_q   <= !hit_d;
            end
            EXEC: begin
               rdata_q <= '0;
               if (hit_q) begin
                  if (we_q) begin
                     if (mm_q) mem_q[id_q] <= wdata_q;
                     if (trigf_q && !src_fab_q) trig_q[id_q] <= 1'b1;
                  end else begin
                     rdata_q <= mm_q ? mem_q[id_q] : ext_arr[id_q];
                     // Only the bus side has read-to-clear semantics; rdata keeps the old value.
                     if (mm_q && cor_q && !src_fab_q) mem_q[id_q] <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule
